// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types and constants for the HD44780 command executor:
//                FSM encodings, control-bit positions, DDRAM opcode and the
//                power-up initialisation ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP      = 3'd0,
        INIT_ISSUE = 3'd1,
        IDLE       = 3'd2,
        ADDR_PH    = 3'd3,
        DATA_PH    = 3'd4,
        DONE       = 3'd5
    } exec_state_e;

    typedef enum logic [2:0] {
        BUS_IDLE  = 3'd0,
        BUS_SETUP = 3'd1,
        BUS_EN    = 3'd2,
        BUS_HOLD  = 3'd3,
        BUS_WAIT  = 3'd4
    } bus_state_e;

    localparam int CTRL_RS   = 0;
    localparam int CTRL_LONG = 1;
    localparam int CTRL_ADDR = 2;

    localparam logic [7:0] DDRAM_SET = 8'h80;

    localparam int         INIT_LEN  = 6;
    localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

    typedef struct packed {
        logic [7:0] db;
        logic       long_wait;
    } init_entry_t;

    // Function set 8-bit/2-line (three times), display on, entry mode, clear
    function automatic init_entry_t init_rom(input logic [2:0] idx);
        init_entry_t e;
        case (idx)
            3'd0:    e = {8'h38, 1'b1};
            3'd1:    e = {8'h38, 1'b0};
            3'd2:    e = {8'h38, 1'b0};
            3'd3:    e = {8'h0C, 1'b0};
            3'd4:    e = {8'h06, 1'b0};
            3'd5:    e = {8'h01, 1'b1};
            default: e = {8'h00, 1'b0};
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_bus_cycle
//  Description : One timed HD44780 write: SETUP (E low, RS/DB driven),
//                EN (E high), HOLD (E low), then the post-write wait.
//                A start pulse latches RS/DB/wait length; done pulses during
//                the final wait cycle so a follow-on write can start gap-free.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 4,
    parameter int unsigned T_SHORT = 1850,
    parameter int unsigned T_LONG  = 76000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] db,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] C_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    bus_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             long_q, long_d;
    logic             e_q, e_d;

    // Phase sequencing; a start always wins so back-to-back writes chain
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        db_d    = db_q;
        long_d  = long_q;
        done    = 1'b0;
        case (state_q)
            BUS_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = BUS_EN;
                    cnt_d   = C_EN;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            BUS_EN: begin
                if (cnt_q == '0) begin
                    state_d = BUS_HOLD;
                    cnt_d   = C_HOLD;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            BUS_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = BUS_WAIT;
                    cnt_d   = long_q ? C_LONG : C_SHORT;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            BUS_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = BUS_IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            default: ;
        endcase
        if (start) begin
            state_d = BUS_SETUP;
            cnt_d   = C_SETUP;
            rs_d    = rs;
            db_d    = db;
            long_d  = long_wait;
        end
    end

    // E follows the next phase so the pin itself is a flop output
    assign e_d = (state_d == BUS_EN);

    // Phase, timer and pin registers; reset drops E asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUS_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            long_q  <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            long_q  <= long_d;
            e_q     <= e_d;
        end
    end

    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;
    assign lcd_db = db_q;

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_exec.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_cmd_exec
//  Description : HD44780 8-bit command executor. Runs the power-up init
//                sequence, then accepts {addr, ctrl, data} commands and
//                issues an optional DDRAM-address write followed by the
//                data/instruction write. Status word reports progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_cmd_exec
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_SETUP   = 4,
    parameter int unsigned T_EN      = 12,
    parameter int unsigned T_HOLD    = 4,
    parameter int unsigned T_SHORT   = 1850,
    parameter int unsigned T_LONG    = 76000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_ctrl,
    input  logic [7:0] cmd_data,
    output logic [7:0] status,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam logic [CNT_W-1:0] C_PWRUP_LAST = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    exec_state_e      state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [2:0]       idx_q, idx_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             long_q, long_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             init_done_q, init_done_d;
    logic             busy_q, busy_d;

    logic             bus_start;
    logic             bus_rs;
    logic [7:0]       bus_db;
    logic             bus_long;
    logic             bus_done;
    logic [2:0]       rom_idx;
    init_entry_t      rom_entry;
    logic             unused_ok;

    // Address MSB and upper control bits carry no meaning here
    assign unused_ok = ^{cmd_addr[7], cmd_ctrl[7:3]};

    // Entry to issue next: first entry out of power-up, else the following one
    assign rom_idx   = (state_q == PWRUP) ? 3'd0 : idx_q + 3'd1;
    assign rom_entry = init_rom(rom_idx);

    // Sequencer: power-up delay, init ROM walk, command phases
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rs_d        = rs_q;
        long_d      = long_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        busy_d      = busy_q;
        bus_start   = 1'b0;
        bus_rs      = 1'b0;
        bus_db      = 8'h00;
        bus_long    = 1'b0;
        case (state_q)
            PWRUP: begin
                if (tmr_q == C_PWRUP_LAST) begin
                    bus_start = 1'b1;
                    bus_db    = rom_entry.db;
                    bus_long  = rom_entry.long_wait;
                    idx_d     = rom_idx;
                    state_d   = INIT_ISSUE;
                end else begin
                    tmr_d = tmr_q + C_ONE;
                end
            end
            INIT_ISSUE: begin
                if (bus_done) begin
                    if (idx_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        bus_start = 1'b1;
                        bus_db    = rom_entry.db;
                        bus_long  = rom_entry.long_wait;
                        idx_d     = rom_idx;
                    end
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr[6:0];
                    data_d    = cmd_data;
                    rs_d      = cmd_ctrl[CTRL_RS];
                    long_d    = cmd_ctrl[CTRL_LONG];
                    busy_d    = 1'b1;
                    bus_start = 1'b1;
                    if (cmd_ctrl[CTRL_ADDR]) begin
                        bus_db  = DDRAM_SET | {1'b0, cmd_addr[6:0]};
                        state_d = ADDR_PH;
                    end else begin
                        bus_rs   = cmd_ctrl[CTRL_RS];
                        bus_db   = cmd_data;
                        bus_long = cmd_ctrl[CTRL_LONG];
                        state_d  = DATA_PH;
                    end
                end
            end
            ADDR_PH: begin
                if (bus_done) begin
                    bus_start = 1'b1;
                    bus_rs    = rs_q;
                    bus_db    = data_q;
                    bus_long  = long_q;
                    state_d   = DATA_PH;
                end
            end
            DATA_PH: begin
                if (bus_done) begin
                    cnt_d   = cnt_q + 4'd1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = PWRUP;
        endcase
    end

    // Sequencer state, captured command and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWRUP;
            tmr_q       <= '0;
            idx_q       <= 3'd0;
            addr_q      <= 7'd0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            long_q      <= 1'b0;
            cnt_q       <= 4'd0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            long_q      <= long_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    lcd_bus_cycle #(
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_SHORT (T_SHORT),
        .T_LONG  (T_LONG),
        .CNT_W   (CNT_W)
    ) u_bus (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (bus_start),
        .rs        (bus_rs),
        .db        (bus_db),
        .long_wait (bus_long),
        .done      (bus_done),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db)
    );

    assign cmd_ready = (state_q == IDLE);
    assign status    = {cnt_q, 2'b00, init_done_q, busy_q};
    assign lcd_rw    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_cmd_exec
//  Description : Self-checking bench for lcd_cmd_exec. A pin monitor records
//                every E pulse; expected bytes, timing and status come from a
//                command-level model of the LCD write protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_exec;

    localparam int T_POWERUP = 100;
    localparam int T_SETUP   = 2;
    localparam int T_EN      = 3;
    localparam int T_HOLD    = 2;
    localparam int T_SHORT   = 10;
    localparam int T_LONG    = 50;
    localparam int CNT_W     = 20;
    localparam int T_BYTE    = T_SETUP + T_EN + T_HOLD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_ctrl;
    logic [7:0] cmd_data;
    logic [7:0] status;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;

    lcd_cmd_exec #(
        .T_POWERUP (T_POWERUP),
        .T_SETUP   (T_SETUP),
        .T_EN      (T_EN),
        .T_HOLD    (T_HOLD),
        .T_SHORT   (T_SHORT),
        .T_LONG    (T_LONG),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_ctrl  (cmd_ctrl),
        .cmd_data  (cmd_data),
        .status    (status),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_count = 0;
    int exp_cnt = 0;
    int rd = 0;

    // Observed E pulses: pins at rise, rise cycle, high width, RS/DB stability
    logic [7:0] obs_db[$];
    logic       obs_rs[$];
    int         obs_rise[$];
    int         obs_w[$];
    bit         obs_st[$];
    logic       e_prev = 1'b0;
    int         e_width = 0;
    logic [8:0] rise_pins = '0;
    logic       busy_prev = 1'b0;

    logic [7:0] init_db[6]   = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    bit         init_long[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Edge counter; at any falling edge it equals the number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitor sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            if (e_prev) begin
                obs_w.push_back(0);
                obs_st.push_back(1'b0);
            end
            e_prev    <= 1'b0;
            e_width   <= 0;
            busy_prev <= 1'b0;
        end else begin
            if (lcd_e && !e_prev) begin
                obs_rs.push_back(lcd_rs);
                obs_db.push_back(lcd_db);
                obs_rise.push_back(cyc);
                rise_pins <= {lcd_rs, lcd_db};
                e_width   <= 1;
            end else if (lcd_e) begin
                e_width <= e_width + 1;
            end
            if (!lcd_e && e_prev) begin
                obs_w.push_back(e_width);
                obs_st.push_back({lcd_rs, lcd_db} == rise_pins);
            end
            e_prev <= lcd_e;
            // a command acceptance shows as busy rising once init is done
            if (status[0] && !busy_prev && status[1]) acc_count <= acc_count + 1;
            busy_prev <= status[0];
        end
    end

    task automatic check_pulse(input logic exp_rs, input logic [7:0] exp_db, input int exp_rise);
        if (rd < obs_db.size() && rd < obs_w.size()) begin
            check_eq("pulse_db", 32'(obs_db[rd]), 32'(exp_db));
            check_eq("pulse_rs", 32'(obs_rs[rd]), 32'(exp_rs));
            check_eq("pulse_rise", obs_rise[rd], exp_rise);
            check_eq("e_width", obs_w[rd], T_EN);
            check_eq("pins_stable", 32'(obs_st[rd]), 32'd1);
            rd++;
        end
    endtask

    task automatic wait_init(input int rel);
        int  n = 0;
        bit  early = 1'b0;
        int  rise;
        while (status[1] !== 1'b1 && n < 3000) begin
            if (cmd_ready) early = 1'b1;
            @(negedge clk);
            n++;
        end
        check_eq("init_timeout", 32'(n < 3000), 32'd1);
        check_eq("ready_before_init", 32'(early), 32'd0);
        check_eq("status_init", 32'(status), 32'h02);
        check_eq("init_pulses", obs_db.size() - rd, 6);
        check_eq("lcd_rw", 32'(lcd_rw), 32'd0);
        rise = rel + T_POWERUP + T_SETUP;
        for (int i = 0; i < 6; i++) begin
            check_pulse(1'b0, init_db[i], rise);
            rise += T_BYTE + (init_long[i] ? T_LONG : T_SHORT);
        end
    endtask

    // Present one command, follow it to completion and compare against the model
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d, input bit keep);
        int         n;
        int         acc;
        int         total;
        int         nb;
        int         rise;
        logic [7:0] e_db[2];
        logic       e_rs[2];
        int         e_wait[2];
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_ctrl  = c;
        cmd_data  = d;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_timeout", 32'(n < 200), 32'd1);
        @(negedge clk);
        acc = cyc;
        check_eq("ready_drop", 32'(cmd_ready), 32'd0);
        check_eq("busy_set", 32'(status[0]), 32'd1);
        if (keep) begin
            cmd_addr = 8'($urandom);
            cmd_ctrl = 8'($urandom);
            cmd_data = 8'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        nb = 0;
        if (c[2]) begin
            e_rs[0]   = 1'b0;
            e_db[0]   = 8'h80 | {1'b0, a[6:0]};
            e_wait[0] = T_SHORT;
            nb = 1;
        end
        e_rs[nb]   = c[0];
        e_db[nb]   = d;
        e_wait[nb] = c[1] ? T_LONG : T_SHORT;
        nb++;
        total = 0;
        for (int i = 0; i < nb; i++) total += T_BYTE + e_wait[i];
        exp_cnt = (exp_cnt + 1) % 16;
        n = 0;
        while (status[7:4] !== exp_cnt[3:0] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_latency", cyc - acc, total);
        check_eq("status_done", 32'(status), 32'({exp_cnt[3:0], 4'b0010}));
        check_eq("ready_in_done", 32'(cmd_ready), 32'd0);
        check_eq("pulse_count", obs_db.size() - rd, nb);
        rise = acc + T_SETUP;
        for (int i = 0; i < nb; i++) begin
            check_pulse(e_rs[i], e_db[i], rise);
            rise += T_BYTE + e_wait[i];
        end
        if (!keep) begin
            @(negedge clk);
            check_eq("ready_after_done", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int base;
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 8'h11;
        cmd_ctrl  = 8'h00;
        cmd_data  = 8'h55;
        repeat (3) @(negedge clk);

        check_eq("rst_status", 32'(status), 32'h01);
        check_eq("rst_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_e", 32'(lcd_e), 32'd0);
        check_eq("rst_rs", 32'(lcd_rs), 32'd0);
        check_eq("rst_db", 32'(lcd_db), 32'd0);
        check_eq("rst_rw", 32'(lcd_rw), 32'd0);

        // init with cmd_valid held high throughout
        rst_n = 1'b1;
        rel   = cyc;
        wait_init(rel);
        check_eq("accepts_during_init", acc_count, 0);

        // 16 back-to-back commands with valid never dropping; counter wraps
        base = acc_count;
        for (int i = 0; i < 16; i++) begin
            send_cmd(8'($urandom), 8'($urandom) & 8'hFD, 8'($urandom), 1'b1);
        end
        check_eq("b2b_accepts", acc_count - base, 16);
        check_eq("status_wrap", 32'(status), 32'h02);

        // directed commands
        send_cmd(8'h05, 8'h01, 8'h41, 1'b0);
        check_eq("status_first", 32'(status), 32'h12);
        send_cmd(8'h45, 8'h05, 8'h42, 1'b0);
        send_cmd(8'h00, 8'h02, 8'h01, 1'b0);

        // random commands with random idle gaps
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_cmd(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end

        // reset while E is high
        cmd_valid = 1'b1;
        cmd_addr  = 8'h00;
        cmd_ctrl  = 8'h01;
        cmd_data  = 8'h5A;
        n = 0;
        while (lcd_e !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("e_seen_before_reset", 32'(lcd_e), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_e", 32'(lcd_e), 32'd0);
        check_eq("midrst_status", 32'(status), 32'h01);
        check_eq("midrst_ready", 32'(cmd_ready), 32'd0);
        check_eq("midrst_db", 32'(lcd_db), 32'd0);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rd      = obs_db.size();
        exp_cnt = 0;
        rst_n   = 1'b1;
        rel     = cyc;
        wait_init(rel);

        send_cmd(8'h47, 8'h05, 8'h7E, 1'b0);
        send_cmd(8'h12, 8'h01, 8'h33, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
